nf_seven_seg_scan: RTL

NF_SEVEN_SEG_SCAN -- requirements
Module: nf_seven_seg_scan

---
 rtl/nf_seven_seg_scan.sv | 114 +++++++++++
 1 files changed

// File: rtl/nf_seven_seg_scan.sv
// Time-multiplexed seven-segment scanner: blanks, then drives one digit at a time
// from a frame snapshot taken at the start of every scan pass.
module nf_seven_seg_scan #(
  parameter int hn    = 8,
  parameter int t_on  = 1000,
  parameter int t_blk = 50
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            en,
  input  logic            cc_ca,
  input  logic [hn*8-1:0] seven_seg_in,
  output logic [7:0]      seg_out,
  output logic [hn-1:0]   dig_sel,
  output logic            frame_start,
  output logic [1:0]      dbg_state
);

  localparam int              IW       = (hn > 1) ? $clog2(hn) : 1;
  localparam logic [15:0]     BLK_LAST = 16'(t_blk - 1);
  localparam logic [15:0]     ON_LAST  = 16'(t_on - 1);
  localparam logic [IW-1:0]   IDX_LAST = IW'(hn - 1);
  localparam logic [IW-1:0]   IDX_ONE  = IW'(1);
  localparam logic [hn-1:0]   DIG_ONE  = hn'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t             r_state;
  logic [IW-1:0]      r_idx;
  logic [15:0]        r_cnt;
  logic [hn*8-1:0]    r_frm;

  logic [7:0]         w_off_seg;
  logic [hn-1:0]      w_off_dig;
  logic [hn-1:0]      w_onehot;
  logic [hn-1:0]      w_on_dig;
  logic [7:0]         w_on_seg;

  // Both encodings follow the live cc_ca so a polarity change shows up at the next edge.
  always_comb begin
    w_off_seg = cc_ca ? 8'hFF : 8'h00;
    w_off_dig = {hn{~cc_ca}};
    w_onehot  = DIG_ONE << r_idx;
    w_on_dig  = cc_ca ? w_onehot : ~w_onehot;
    w_on_seg  = r_frm[r_idx*8 +: 8];
  end

  assign dbg_state = r_state;

  // Outputs are computed from the next state so they line up with it one cycle later.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_frm       <= '0;
      seg_out     <= 8'h00;
      dig_sel     <= '0;
      frame_start <= 1'b0;
    end else if (!en) begin
      r_state     <= IDLE;
      seg_out     <= w_off_seg;
      dig_sel     <= w_off_dig;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      seg_out     <= w_off_seg;
      dig_sel     <= w_off_dig;
      case (r_state)
        IDLE: begin
          r_frm       <= seven_seg_in;
          r_idx       <= '0;
          r_cnt       <= '0;
          frame_start <= 1'b1;
          r_state     <= BLANK;
        end
        BLANK: begin
          if (r_cnt == BLK_LAST) begin
            r_cnt   <= '0;
            r_state <= SHOW;
            seg_out <= w_on_seg;
            dig_sel <= w_on_dig;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        SHOW: begin
          if (r_cnt == ON_LAST) begin
            r_cnt   <= '0;
            r_state <= BLANK;
            // Last digit closes the frame: take a fresh snapshot for the next pass.
            if (r_idx == IDX_LAST) begin
              r_idx       <= '0;
              r_frm       <= seven_seg_in;
              frame_start <= 1'b1;
            end else begin
              r_idx <= r_idx + IDX_ONE;
            end
          end else begin
            r_cnt   <= r_cnt + 16'd1;
            seg_out <= w_on_seg;
            dig_sel <= w_on_dig;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
